// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_LUI  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12;
  localparam logic [3:0] OP_REMU = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FLAG_OVF   = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_DIVZ  = 3;
  localparam int FLAG_ILL   = 4;
  localparam int NUM_FLAGS  = 5;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: shift-add multiply (LSB first) and restoring unsigned divide (MSB first),
// one step per cycle. Outputs expose the value after the current step so the last one can be latched at once.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);

  // acc: product accumulator or partial remainder; opa: multiplier or dividend/quotient;
  // opb: multiplicand (shifted left) or divisor.
  logic             active_q, active_d;
  logic             is_div_q, is_div_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    active_d = active_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    shifted  = {acc_q, opa_q[WIDTH-1]};
    diff     = shifted - {1'b0, opb_q};
    if (start) begin
      active_d = 1'b1;
      is_div_d = is_div;
      cnt_d    = '0;
      acc_d    = '0;
      opa_d    = x;
      opb_d    = y;
    end else if (active_q) begin
      if (is_div_q) begin
        if (!diff[WIDTH]) begin
          acc_d = diff[WIDTH-1:0];
          opa_d = {opa_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          opa_d = {opa_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        if (opa_q[0]) acc_d = acc_q + opb_q;
        opa_d = opa_q >> 1;
        opb_d = opb_q << 1;
      end
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) active_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      active_q <= active_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
    end
  end

  assign done    = active_q && (cnt_q == LAST);
  assign prod_lo = acc_d;
  assign quot    = opa_d;
  assign rem     = acc_d;

endmodule

// File: rtl/alu_mc.sv
// Handshaked ALU: single-cycle ops finish on accept, MUL/DIVU/REMU run in the iterative engine.
// Result and flags are registered and held in DONE until the consumer takes them.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             div_zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  state_e                 state_q, state_d;
  logic [3:0]             op_q, op_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic [NUM_FLAGS-1:0]   flags_q, flags_d;

  logic                   sub_like, add_ovf, is_iter, start;
  logic [WIDTH-1:0]       b_op, alu_res, iter_res;
  logic [WIDTH:0]         sum_w;
  logic [NUM_FLAGS-1:0]   alu_flags;
  logic                   it_done;
  logic [WIDTH-1:0]       it_prod, it_quot, it_rem;

  // Single-cycle datapath, evaluated on the presented operands.
  always_comb begin
    sub_like  = (op == OP_SUB) || (op == OP_SLT);
    b_op      = sub_like ? ~y : y;
    sum_w     = {1'b0, x} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_like};
    add_ovf   = (x[MSB] == b_op[MSB]) && (sum_w[MSB] != x[MSB]);
    alu_res   = '0;
    alu_flags = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        alu_res              = sum_w[WIDTH-1:0];
        alu_flags[FLAG_OVF]   = add_ovf;
        alu_flags[FLAG_CARRY] = sum_w[WIDTH];
      end
      OP_AND:  alu_res = x & y;
      OP_OR:   alu_res = x | y;
      OP_XOR:  alu_res = x ^ y;
      OP_NOR:  alu_res = ~(x | y);
      OP_LUI:  alu_res = {y[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      // Sign of the difference corrected by overflow gives the true signed compare.
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum_w[MSB] ^ add_ovf};
      OP_SLL:  alu_res = x << y[SHW-1:0];
      OP_SRL:  alu_res = x >> y[SHW-1:0];
      OP_SRA:  alu_res = $signed(x) >>> y[SHW-1:0];
      OP_MUL:  alu_res = '0;
      OP_DIVU: begin
        alu_res             = '1;
        alu_flags[FLAG_DIVZ] = 1'b1;
      end
      OP_REMU: begin
        alu_res             = x;
        alu_flags[FLAG_DIVZ] = 1'b1;
      end
      default: alu_flags[FLAG_ILL] = 1'b1;
    endcase
    alu_flags[FLAG_ZERO] = (alu_res == '0);
  end

  assign is_iter  = (op == OP_MUL) || (((op == OP_DIVU) || (op == OP_REMU)) && (y != '0));
  assign iter_res = (op_q == OP_MUL)  ? it_prod :
                    (op_q == OP_DIVU) ? it_quot : it_rem;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    start    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d = op;
          if (is_iter) begin
            start   = 1'b1;
            state_d = ST_BUSY;
          end else begin
            result_d = alu_res;
            flags_d  = alu_flags;
            state_d  = ST_DONE;
          end
        end
      end
      ST_BUSY: begin
        if (it_done) begin
          result_d            = iter_res;
          flags_d             = '0;
          flags_d[FLAG_ZERO]  = (iter_res == '0);
          state_d             = ST_DONE;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .is_div  ((op == OP_DIVU) || (op == OP_REMU)),
    .x       (x),
    .y       (y),
    .done    (it_done),
    .prod_lo (it_prod),
    .quot    (it_quot),
    .rem     (it_rem)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign overflow  = flags_q[FLAG_OVF];
  assign carry     = flags_q[FLAG_CARRY];
  assign zero      = flags_q[FLAG_ZERO];
  assign div_zero  = flags_q[FLAG_DIVZ];
  assign illegal   = flags_q[FLAG_ILL];

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=32: results, flags, latency, backpressure and reset mid-operation.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] x, y, result;
  logic             overflow, carry, zero, div_zero, illegal;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .carry     (carry),
    .zero      (zero),
    .div_zero  (div_zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Present one operation for one accepting edge; returns at the negedge after the accept.
  task automatic issue(input logic [3:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    op = o; x = a; y = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Latency in cycles counted from the accepting edge; saw_ready flags in_ready seen while waiting.
  task automatic wait_out(output int lat, output bit saw_ready);
    lat = 1;
    saw_ready = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) saw_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, in_ready, overflow, carry, zero, div_zero, illegal} !== 7'b0100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0100000",
               {out_valid, in_ready, overflow, carry, zero, div_zero, illegal});
    end
    checks++;
    if (result !== '0) begin
      errors++;
      $display("FAIL reset_result: got %h expected 00000000", result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    int lat; bit sr;
    issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_out(lat, sr);
    checks++;
    if (lat !== 1 || result !== 32'h8000_0000 || {overflow, carry, zero} !== 3'b100) begin
      errors++;
      $display("FAIL add_ovf: got lat=%0d res=%h ovf/c/z=%b expected lat=1 res=80000000 ovf/c/z=100",
               lat, result, {overflow, carry, zero});
    end
    consume();
    issue(OP_SUB, 32'd5, 32'd5);
    wait_out(lat, sr);
    checks++;
    if (lat !== 1 || result !== 32'h0 || {overflow, carry, zero} !== 3'b011) begin
      errors++;
      $display("FAIL sub_zero: got lat=%0d res=%h ovf/c/z=%b expected lat=1 res=00000000 ovf/c/z=011",
               lat, result, {overflow, carry, zero});
    end
    consume();
  endtask

  task automatic test_logic_shift();
    logic [3:0]       ops [6] = '{OP_SLT, OP_LUI, OP_SRA, OP_SLL, OP_XOR, OP_NOR};
    logic [WIDTH-1:0] xs  [6] = '{32'h8000_0000, 32'h0, 32'h8000_0000, 32'h1,
                                  32'hF0F0_F0F0, 32'h0};
    logic [WIDTH-1:0] ys  [6] = '{32'h1, 32'h1234_ABCD, 32'd31, 32'h24,
                                  32'hFF00_FF00, 32'h0};
    logic [WIDTH-1:0] exp [6] = '{32'h1, 32'hABCD_0000, 32'hFFFF_FFFF, 32'h10,
                                  32'h0FF0_0FF0, 32'hFFFF_FFFF};
    int lat; bit sr;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], xs[i], ys[i]);
      wait_out(lat, sr);
      checks++;
      if (lat !== 1 || result !== exp[i] || {overflow, carry, zero, illegal} !== 4'b0000) begin
        errors++;
        $display("FAIL single_op%0d: got lat=%0d res=%h ovf/c/z/ill=%b expected lat=1 res=%h flags=0000",
                 ops[i], lat, result, {overflow, carry, zero, illegal}, exp[i]);
      end
      consume();
    end
  endtask

  task automatic test_mul();
    int lat; bit sr;
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_out(lat, sr);
    checks++;
    if (lat !== WIDTH + 1) begin
      errors++;
      $display("FAIL mul_latency: got %0d expected %0d", lat, WIDTH + 1);
    end
    checks++;
    if (sr !== 1'b0) begin
      errors++;
      $display("FAIL mul_in_ready: got in_ready high during BUSY expected low");
    end
    checks++;
    if (result !== 32'h1 || {overflow, carry, zero} !== 3'b000) begin
      errors++;
      $display("FAIL mul_result: got %h flags=%b expected 00000001 flags=000",
               result, {overflow, carry, zero});
    end
    consume();
  endtask

  task automatic test_div();
    int lat; bit sr;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_out(lat, sr);
    checks++;
    if (lat !== WIDTH + 1 || result !== 32'd14 || div_zero !== 1'b0) begin
      errors++;
      $display("FAIL divu: got lat=%0d res=%h dz=%b expected lat=33 res=0000000e dz=0",
               lat, result, div_zero);
    end
    consume();
    issue(OP_REMU, 32'd100, 32'd7);
    wait_out(lat, sr);
    checks++;
    if (lat !== WIDTH + 1 || result !== 32'd2) begin
      errors++;
      $display("FAIL remu: got lat=%0d res=%h expected lat=33 res=00000002", lat, result);
    end
    consume();
    issue(OP_DIVU, 32'd9, 32'd0);
    wait_out(lat, sr);
    checks++;
    if (lat !== 1 || result !== 32'hFFFF_FFFF || div_zero !== 1'b1) begin
      errors++;
      $display("FAIL divu_by_zero: got lat=%0d res=%h dz=%b expected lat=1 res=ffffffff dz=1",
               lat, result, div_zero);
    end
    consume();
    issue(OP_REMU, 32'd9, 32'd0);
    wait_out(lat, sr);
    checks++;
    if (lat !== 1 || result !== 32'd9 || div_zero !== 1'b1) begin
      errors++;
      $display("FAIL remu_by_zero: got lat=%0d res=%h dz=%b expected lat=1 res=00000009 dz=1",
               lat, result, div_zero);
    end
    consume();
  endtask

  task automatic test_illegal();
    int lat; bit sr;
    for (int o = 14; o < 16; o++) begin
      issue(4'(o), 32'd5, 32'd5);
      wait_out(lat, sr);
      checks++;
      if (lat !== 1 || result !== 32'h0 || {illegal, zero, div_zero} !== 3'b110) begin
        errors++;
        $display("FAIL illegal_op%0d: got lat=%0d res=%h ill/z/dz=%b expected lat=1 res=0 ill/z/dz=110",
                 o, lat, result, {illegal, zero, div_zero});
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit sr; bit unstable;
    issue(OP_MUL, 32'd3, 32'd5);
    wait_out(lat, sr);
    checks++;
    if (lat !== WIDTH + 1 || result !== 32'd15) begin
      errors++;
      $display("FAIL bp_mul: got lat=%0d res=%h expected lat=33 res=0000000f", lat, result);
    end
    op = OP_ADD; x = 32'd1; y = 32'd1; in_valid = 1'b1;
    unstable = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (result !== 32'd15 || out_valid !== 1'b1 || in_ready !== 1'b0) unstable = 1'b1;
    end
    checks++;
    if (unstable) begin
      errors++;
      $display("FAIL bp_hold: got res=%h ov=%b ir=%b expected res=0000000f ov=1 ir=0 for 5 cycles",
               result, out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd15) begin
      errors++;
      $display("FAIL bp_release: got ir=%b ov=%b res=%h expected ir=1 ov=0 res=0000000f",
               in_ready, out_valid, result);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 32'd2) begin
      errors++;
      $display("FAIL bp_next_op: got ov=%b res=%h expected ov=1 res=00000002", out_valid, result);
    end
    consume();
  endtask

  task automatic test_reset_mid_mul();
    bit seen_valid;
    issue(OP_MUL, 32'd7, 32'd9);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, overflow, carry, zero, div_zero, illegal} !== 7'b0100000 ||
        result !== '0) begin
      errors++;
      $display("FAIL reset_busy: got ctrl=%b res=%h expected ctrl=0100000 res=00000000",
               {out_valid, in_ready, overflow, carry, zero, div_zero, illegal}, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_output: got out_valid_seen=%b ir=%b expected 0 and 1",
               seen_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_mul();
    test_div();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
